// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit.
// Holds the funct3 encodings, FSM states, fault causes and default MMIO window.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h0000_0200;
  localparam logic [31:0] DEF_MMIO_LAST = 32'h0000_0202;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering, fault detection and load extraction.
// LSU_MMIO_LANE0_EN forces byte accesses in the MMIO window onto lane 0 and faults wider ones.
module lsu_align
  import lsu_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_LAST = DEF_MMIO_LAST
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteena_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  output logic [1:0]  cause_o,
  output logic [31:0] rdata_o
);

`ifdef LSU_MMIO_LANE0_EN
  localparam bit MMIO_LANE0 = 1'b1;
`else
  localparam bit MMIO_LANE0 = 1'b0;
`endif

  logic        in_mmio;
  logic        illegal;
  logic        misalign;
  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    in_mmio = MMIO_LANE0 && (addr_i >= MMIO_BASE) && (addr_i <= MMIO_LAST);
    illegal = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110) || (we_i && funct3_i[2]);

    case (funct3_i[1:0])
      2'b01:   misalign = addr_i[0];
      2'b10:   misalign = (addr_i[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    // UART registers are byte-wide only: wider accesses there are rejected
    if (in_mmio && (funct3_i[1:0] != 2'b00)) misalign = 1'b1;

    lane = in_mmio ? 2'b00 : addr_i[1:0];

    case (funct3_i[1:0])
      2'b00: begin
        byteena_o = 4'b0001 << lane;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        byteena_o = 4'b0011 << lane;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      default: begin
        byteena_o = 4'b1111;
        wdata_o   = wdata_i;
      end
    endcase

    shifted = rdata_i >> {lane, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_o = {24'h0, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = rdata_i;
    endcase

    fault_o = illegal || misalign;
    cause_o = illegal ? CAUSE_ILLEGAL : (misalign ? CAUSE_MISALIGN : CAUSE_NONE);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store FSM between execute stage and MMU port.
// Optional LSU_MMIO_LANE0_EN (see lsu_align) pins MMIO byte accesses to lane 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_LAST = DEF_MMIO_LAST
) (
  input  logic        clock,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic [31:0] vaddr,
  output logic [31:0] data,
  output logic [3:0]  byteena,
  output logic        memWE,
  input  logic        memWait,
  input  logic [31:0] q
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic        in_idle, in_issue;
  logic [3:0]  al_be;
  logic [31:0] al_data, al_rdata;
  logic        al_fault;
  logic [1:0]  al_cause;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_issue = (state_q == ST_ISSUE);

  // One aligner serves both the live request (fault check at accept) and the latched one
  lsu_align #(
    .MMIO_BASE (MMIO_BASE),
    .MMIO_LAST (MMIO_LAST)
  ) u_align (
    .we_i      (in_idle ? req_we     : we_q),
    .funct3_i  (in_idle ? req_funct3 : f3_q),
    .addr_i    (in_idle ? req_addr   : addr_q),
    .wdata_i   (in_idle ? req_wdata  : wdata_q),
    .rdata_i   (q),
    .byteena_o (al_be),
    .wdata_o   (al_data),
    .fault_o   (al_fault),
    .cause_o   (al_cause),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 3'd0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    cause_d = cause_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          fault_d = al_fault;
          cause_d = al_cause;
          state_d = al_fault ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!memWait) begin
          cnt_d   = CNT_INIT;
          state_d = we_q ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!memWait) begin
          if (cnt_q == 3'd0) begin
            rdata_d = al_rdata;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = in_idle & RST_N;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_fault = resp_valid & fault_q;
  assign resp_cause = resp_valid ? cause_q : CAUSE_NONE;

  assign vaddr   = in_issue ? addr_q  : 32'h0;
  assign data    = in_issue ? al_data : 32'h0;
  assign byteena = in_issue ? al_be   : 4'h0;
  assign memWE   = in_issue & we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a reference model.
// Reference model honours LSU_MMIO_LANE0_EN when the bundle is built with it.
module tb_load_store_unit;

  localparam int RD_LAT = 2;

  logic        clock = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic [31:0] vaddr;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        memWE;
  logic        memWait = 1'b0;
  logic [31:0] q = 32'h0;

  load_store_unit #(.RD_LAT(RD_LAT)) dut (
    .clock(clock), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_cause(resp_cause), .vaddr(vaddr), .data(data), .byteena(byteena),
    .memWE(memWE), .memWait(memWait), .q(q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] vaddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } iss_t;

  resp_t exp_resp[$];
  iss_t  exp_iss[$];

  // Architectural view: size in bytes, lane = address modulo 4, replicate and extend arithmetically
  function automatic void ref_model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                    input bit [31:0] wdata, input bit [31:0] qword,
                                    output bit fault, output bit [1:0] cause, output bit [3:0] be,
                                    output bit [31:0] sdata, output bit [31:0] ldata);
    int n, lane;
    bit illegal, mis, mmio;
    bit [31:0] v, mask;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
    n = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    lane = int'(addr % 4);
    mis = (addr % n) != 0;
    mmio = 1'b0;
`ifdef LSU_MMIO_LANE0_EN
    mmio = (addr >= 32'h200) && (addr <= 32'h202);
`endif
    if (mmio) begin
      lane = 0;
      if (n > 1) mis = 1'b1;
    end
    fault = illegal || mis;
    cause = illegal ? 2'd2 : (mis ? 2'd1 : 2'd0);
    be = 4'b0;
    for (int i = 0; i < n; i++) if (lane + i < 4) be[lane + i] = 1'b1;
    for (int i = 0; i < 4; i++) sdata[8*i +: 8] = wdata[8*(i % n) +: 8];
    v = qword >> (8 * lane);
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (f3 < 4 && v[8*n - 1]) v = v | ~mask;
    end
    ldata = (we || fault) ? 32'h0 : v;
  endfunction

  // Monitor: compares whatever the DUT presents against the front of the queues
  always @(negedge clock) begin
    resp_t e;
    #1;
    if (RST_N) begin
      if (byteena != 4'b0 || memWE) begin
        if (exp_iss.size() == 0) chk("unexpected_issue", {27'b0, memWE, byteena}, 32'h0);
        else begin
          chk("issue_vaddr", vaddr, exp_iss[0].vaddr);
          chk("issue_data", data, exp_iss[0].data);
          chk("issue_byteena", {28'b0, byteena}, {28'b0, exp_iss[0].be});
          chk("issue_memWE", {31'b0, memWE}, {31'b0, exp_iss[0].we});
          if (!memWait) void'(exp_iss.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        else begin
          e = exp_resp.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
          chk("resp_cause", {30'b0, resp_cause}, {30'b0, e.cause});
          chk("resp_cycle", cyc, e.cyc);
        end
      end else begin
        chk("resp_idle_zero", resp_rdata | {29'b0, resp_fault, resp_cause}, 32'h0);
      end
    end
  end

  task automatic do_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit [31:0] qword,
                        input int s, input int w, input bit abort);
    bit fault;
    bit [1:0] cause;
    bit [3:0] be;
    bit [31:0] sdata, ldata;
    int guard, a, last;
    resp_t r;
    iss_t  is;
    ref_model(we, f3, addr, wdata, qword, fault, cause, be, sdata, ldata);
    if (we || fault) abort = 1'b0;

    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    memWait = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    a = cyc;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    r.rdata = ldata; r.fault = fault; r.cause = cause;
    if (fault) r.cyc = a;
    else if (we) r.cyc = a + s + 1;
    else r.cyc = a + s + 1 + RD_LAT + w;
    if (!abort) exp_resp.push_back(r);
    if (!fault) begin
      is.vaddr = addr; is.data = sdata; is.be = be; is.we = we;
      exp_iss.push_back(is);
    end

    if (!fault) begin
      last = we ? s + 1 : s + 1 + RD_LAT + w;
      for (int k = 0; k <= last; k++) begin
        if (k > 0) @(negedge clock);
        memWait = (k < s) || (!we && k > s && k <= s + w);
        q = (!we && k == s + RD_LAT + w) ? qword : $urandom;
        if (abort && k == s + 1) begin
          RST_N = 1'b0;
          #1;
          chk("rst_byteena", {28'b0, byteena}, 32'h0);
          chk("rst_memWE", {31'b0, memWE}, 32'h0);
          chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
          chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
          chk("rst_vaddr", vaddr | data, 32'h0);
          @(negedge clock);
          RST_N = 1'b1;
          memWait = 1'b0;
          return;
        end
      end
      memWait = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [31:0] addr;
    RST_N = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset_mem_port", {27'b0, memWE, byteena} | vaddr | data, 32'h0);
    chk("reset_resp_data", resp_rdata | {29'b0, resp_fault, resp_cause}, 32'h0);
    @(negedge clock);
    RST_N = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

    do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0);
    do_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    do_txn(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0);
    do_txn(1'b0, 3'b101, 32'h106, 32'h0, 32'hF00D1234, 0, 0, 1'b0);
    do_txn(1'b1, 3'b001, 32'h102, 32'hABCD1234, 32'h0, 1, 0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h108, 32'h0, 32'h11112222, 0, 1, 1'b1);
    do_txn(1'b0, 3'b010, 32'h10C, 32'h0, 32'h33334444, 0, 0, 1'b0);
    do_txn(1'b1, 3'b000, 32'h201, 32'h41, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 3'b100, 32'h200, 32'h0, 32'h00000003, 0, 0, 1'b0);
    do_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h12345678, 0, 0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) addr = $urandom;
      else addr = 32'h1F0 + $urandom_range(0, 31);
      do_txn(1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 15) == 0));
    end

    repeat (10) @(negedge clock);
    chk("resp_queue_drained", exp_resp.size(), 32'h0);
    chk("issue_queue_drained", exp_iss.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
